mult_share_sched: RTL and testbench
===================================

Name: mult_share_sched

Overview:
- Round-robin scheduler that shares one 8x8 approximate/Wallace multiplier datapath among NREQ requesters.
- Accepts one operand pair at a time and registers operands onto the multiplier inputs.
- Waits a programmable settle latency, captures the product, and returns it with the requester ID under valid/ready backpressure.
- Sits between client blocks (filters, MAC sequencers) and the single shared multiplier instance, which is external to this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width; product width is 2*W.
- ID_W, 2, width of requester ID; must satisfy 2^ID_W >= NREQ.
- MUL_LAT, 1, cycles operands are held on mul_a/mul_b before mul_p is sampled (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*W  packed operand A; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  packed operand B, same packing as req_a.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- mul_a  out  W  registered operand A to the shared multiplier.
- mul_b  out  W  registered operand B to the shared multiplier.
- mul_p  in  2*W  product from the shared multiplier.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_id  out  ID_W  index of the requester that owns the result.
- res_product  out  2*W  captured product.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: while rst_n=0 at a rising edge:
  - state=IDLE, rr_ptr=0, cnt=0.
  - mul_a=0, mul_b=0, res_product=0, res_id=0, res_valid=0.
  - req_ready=0 (combinational from state, so it is also 0 in IDLE with no valid requests), busy=0.
- Reset mid-operation: the in-flight transaction is discarded silently. No result is produced and no requester is re-acknowledged.
- States: IDLE, CALC, HOLD.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[grant]=1 combinationally; all other bits are 0. No grant if no valid request.
  - On handshake (req_valid[g] & req_ready[g]) at an edge:
    - mul_a <= req_a[g], mul_b <= req_b[g], res_id <= g.
    - cnt <= MUL_LAT-1, rr_ptr <= (g+1) mod NREQ, state <= CALC.
- CALC:
  - req_ready all 0. mul_a/mul_b stay stable.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: res_product <= mul_p, res_valid <= 1, state <= HOLD.
- HOLD:
  - res_valid=1. res_id and res_product are stable until handshake. req_ready all 0.
  - On res_valid & res_ready at an edge: res_valid <= 0, state <= IDLE.
  - No new request is accepted in that same cycle.
- Latency: request accepted at edge k -> product sampled at edge k+MUL_LAT -> res_valid high from that edge.
  - Minimum turnaround per operation is MUL_LAT+2 cycles (accept, settle, result handshake).
- mul_a/mul_b keep their last operands in IDLE and HOLD; they are not zeroed, to avoid toggling the multiplier.
- A requester may deassert req_valid before it is granted; no effect on arbitration.
- Requester operands need only be valid in the handshake cycle.
- rr_ptr updates only on grant, so requests that arrive simultaneously are served in strict rotation. A requester waits at most NREQ-1 grants.
- Arithmetic is pass-through: res_product equals mul_p sampled at the capture edge. No rounding and no correction of the approximate product.
- res_ready is ignored outside HOLD.
- req_valid bits for indices >= NREQ do not exist; res_id never exceeds NREQ-1.

Test Plan:
- Single request: after reset, req_valid=4'b0001, a=13, b=11, with an exact-product multiplier stub and MUL_LAT=1.
  - req_ready[0] high in the accept cycle.
  - res_valid rises 1 edge later with res_product=143, res_id=0.
  - busy high from accept through the result handshake.
- Contention: all four req_valid held high continuously, each with distinct operands, res_ready=1.
  - Grants occur in order 0,1,2,3,0.
  - res_id sequence is 0,1,2,3,0 with the matching products.
  - Exactly one req_ready bit is high per grant; none is high in CALC or HOLD.
- Backpressure: res_ready=0 for 5 cycles during HOLD with a=255, b=255.
  - res_product=65025 and res_id held stable throughout.
  - req_ready=0 throughout.
  - Completes on the first cycle res_ready=1; the next grant comes no earlier than the following cycle.
- Latency parameter: MUL_LAT=3, stub returns mul_a*mul_b only after operands have been stable for 3 cycles.
  - res_valid asserts exactly 3 edges after accept with the correct product.
  - mul_a/mul_b unchanged during CALC.
- Reset mid-CALC: assert rst_n=0 for 1 cycle during CALC.
  - All outputs return to reset values; no res_valid pulse follows.
  - The next request from requester 2 is granted first (rr_ptr=0 and only requester 2 is valid).
- Fairness with late arrival: requester 1 holds valid while requester 3 raises valid only after requester 1 is granted.
  - Requester 3 is granted next, even though requester 1 re-requests.

Source files
------------

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin front end for one shared W x W multiplier.
// One operand pair is in flight at a time. The pair is registered onto
// mul_a/mul_b. After MUL_LAT cycles mul_p is captured, and the result is
// offered with its requester ID until the consumer takes it.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A requester may raise or drop req_valid freely before
// it is granted. Once res_valid is high, res_id and res_product are held
// stable until the edge that completes res_valid & res_ready.
module mult_share_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    input  logic [2*W-1:0]      mul_p,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ID_W-1:0]     res_id,
    output logic [2*W-1:0]      res_product,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // MUL_LAT is at most 15, so four bits always hold the settle count.
    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;
    logic             accept;

    // Requester index at offset 'off' from 'base', wrapping modulo NREQ.
    function automatic logic [ID_W-1:0] rr_index(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NREQ) s = s - NREQ;
        return ID_W'(s);
    endfunction

    // Round-robin search: scan from the highest offset down so the lowest
    // offset from rr_ptr with a valid request wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[rr_index(int'(rr_ptr), k)]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_index(int'(rr_ptr), k);
            end
        end
    end

    // Only IDLE offers a grant; at most one ready bit is ever high.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_valid) req_ready[grant_idx] = 1'b1;
    end

    assign accept    = (state == IDLE) && grant_valid;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Scheduler FSM, operand registers and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            res_product <= '0;
            res_id      <= '0;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_a  <= req_a[grant_idx*W +: W];
                        mul_b  <= req_b[grant_idx*W +: W];
                        res_id <= grant_idx;
                        cnt    <= CNT_INIT;
                        rr_ptr <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // Operands stay on mul_a/mul_b while the multiplier settles.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        res_product <= mul_p;
                        res_valid   <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // Return to IDLE only; the next grant is offered a cycle later.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: a MUL_LAT=3 instance with random and directed
// traffic against an occupancy-level reference model, plus a MUL_LAT=1
// instance for the single-request timing case.
module tb_mult_share_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (MUL_LAT = 3) ----------------
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_p;
    logic        res_valid, res_ready;
    logic [1:0]  res_id;
    logic [15:0] res_product;
    logic        busy;
    logic [1:0]  dbg_state;

    mult_share_sched #(.NREQ(NREQ), .W(8), .ID_W(2), .MUL_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_product(res_product), .busy(busy), .dbg_state(dbg_state)
    );

    // Multiplier stub: exact product only once the operands have been held
    // for LAT cycles, a corrupted value before that.
    logic [7:0] st_prev_a = 8'd0, st_prev_b = 8'd0;
    int         st_age = 0;
    int         cur_age;
    always @(posedge clk) begin
        st_prev_a <= mul_a;
        st_prev_b <= mul_b;
        if (mul_a != st_prev_a || mul_b != st_prev_b) st_age <= 1;
        else if (st_age < 100) st_age <= st_age + 1;
    end
    assign cur_age = (mul_a != st_prev_a || mul_b != st_prev_b) ? 0 : st_age;
    assign mul_p = (cur_age >= LAT - 1) ? 16'(mul_a) * 16'(mul_b)
                                        : (16'(mul_a) * 16'(mul_b)) ^ 16'h5A5A;

    // ---------------- small DUT (MUL_LAT = 1) ----------------
    logic        s_rst_n;
    logic [3:0]  s_req_valid;
    logic [31:0] s_req_a, s_req_b;
    logic [3:0]  s_req_ready;
    logic [7:0]  s_mul_a, s_mul_b;
    logic [15:0] s_mul_p;
    logic        s_res_valid, s_res_ready;
    logic [1:0]  s_res_id;
    logic [15:0] s_res_product;
    logic        s_busy;
    logic [1:0]  s_dbg_state;

    mult_share_sched #(.NREQ(NREQ), .W(8), .ID_W(2), .MUL_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(s_rst_n), .req_valid(s_req_valid), .req_a(s_req_a), .req_b(s_req_b),
        .req_ready(s_req_ready), .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_p(s_mul_p),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_id(s_res_id),
        .res_product(s_res_product), .busy(s_busy), .dbg_state(s_dbg_state)
    );
    assign s_mul_p = 16'(s_mul_a) * 16'(s_mul_b);

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [17:0] exp_q[$];      // {id, product}
    int          grant_log[$];  // grants observed on the DUT

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int first_from(input int ptr, input logic [3:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    // ---------------- reference model / predictor ----------------
    // Model phases: 0 free, 1 settling, 2 result offered.
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_el    = 0;
    logic [7:0] m_a, m_b;
    int         p_g;
    logic [3:0] p_ready;
    logic [3:0] hs;

    // Checks grant/busy/valid timing each cycle and pushes expected results.
    always @(negedge clk) begin
        if (chk_en) begin
            p_g     = (m_phase == 0) ? first_from(m_ptr, req_valid) : -1;
            p_ready = 4'b0;
            if (p_g >= 0) p_ready[p_g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(p_ready));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("res_valid", 32'(res_valid), 32'(m_phase == 2));
            if (m_phase != 0) begin
                chk("mul_a_hold", 32'(mul_a), 32'(m_a));
                chk("mul_b_hold", 32'(mul_b), 32'(m_b));
            end
            hs = req_valid & req_ready;
            if (rst_n && hs != 4'b0)
                for (int i = 0; i < NREQ; i++) if (hs[i]) grant_log.push_back(i);
            if (!rst_n) begin
                m_phase = 0;
                m_ptr   = 0;
                exp_q.delete();
            end else begin
                case (m_phase)
                    0: if (p_g >= 0) begin
                        m_a = req_a[p_g*8 +: 8];
                        m_b = req_b[p_g*8 +: 8];
                        exp_q.push_back({2'(p_g), 16'(int'(m_a) * int'(m_b))});
                        m_ptr   = (p_g + 1) % NREQ;
                        m_el    = 0;
                        m_phase = 1;
                    end
                    1: begin
                        m_el++;
                        if (m_el == LAT) m_phase = 2;
                    end
                    default: if (res_ready) m_phase = 0;
                endcase
            end
        end
    end

    // Monitor: compares every offered result against the queue head.
    always @(negedge clk) begin
        if (chk_en && rst_n && res_valid) begin
            if (exp_q.size() == 0) begin
                chk("res_unexpected", 32'(1), 32'(0));
            end else begin
                chk("res_id", 32'(res_id), 32'(exp_q[0][17:16]));
                chk("res_product", 32'(res_product), 32'(exp_q[0][15:0]));
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mul_a"}, 32'(mul_a), 32'(0));
        chk({tag, "_mul_b"}, 32'(mul_b), 32'(0));
        chk({tag, "_res_product"}, 32'(res_product), 32'(0));
        chk({tag, "_res_id"}, 32'(res_id), 32'(0));
        chk({tag, "_res_valid"}, 32'(res_valid), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_dbg_state"}, 32'(dbg_state), 32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    task automatic wait_grants(input int n, input string nm);
        for (int t = 0; t < 200 && grant_log.size() < n; t++) cyc(1);
        if (grant_log.size() < n) chk({nm, "_timeout"}, 32'(grant_log.size()), 32'(n));
    endtask

    // ---------------- main stimulus ----------------
    task automatic run_main();
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check_reset_vals("rst");
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single request
        req_valid = 4'b0001; req_a[7:0] = 8'd13; req_b[7:0] = 8'd11;
        cyc(1);
        req_valid = '0;
        cyc(8);

        // contention, strict rotation
        do_reset();
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*8 +: 8] = 8'(20 + i * 17);
            req_b[i*8 +: 8] = 8'(3 + i * 29);
        end
        req_valid = 4'b1111;
        wait_grants(5, "contention");
        if (grant_log.size() >= 5) begin
            chk("rot0", 32'(grant_log[0]), 32'(0));
            chk("rot1", 32'(grant_log[1]), 32'(1));
            chk("rot2", 32'(grant_log[2]), 32'(2));
            chk("rot3", 32'(grant_log[3]), 32'(3));
            chk("rot4", 32'(grant_log[4]), 32'(0));
        end
        req_valid = '0;
        cyc(10);

        // backpressure on 255*255
        res_ready = 1'b0;
        req_a[23:16] = 8'd255; req_b[23:16] = 8'd255;
        req_valid = 4'b0100;
        for (int t = 0; t < 50 && !res_valid; t++) cyc(1);
        chk("bp_res_valid_seen", 32'(res_valid), 32'(1));
        for (int t = 0; t < 5; t++) begin
            cyc(1);
            chk("bp_product", 32'(res_product), 32'(65025));
            chk("bp_id", 32'(res_id), 32'(2));
            chk("bp_req_ready", 32'(req_ready), 32'(0));
        end
        res_ready = 1'b1;
        cyc(2);
        req_valid = '0;
        cyc(10);

        // reset while settling
        req_valid = 4'b0001; req_a[7:0] = 8'($urandom); req_b[7:0] = 8'($urandom);
        cyc(1);
        req_valid = '0;
        cyc(1);
        do_reset();
        check_reset_vals("midrst");
        cyc(6);
        grant_log.delete();
        req_valid = 4'b0100; req_a[23:16] = 8'd7; req_b[23:16] = 8'd9;
        wait_grants(1, "after_rst");
        if (grant_log.size() >= 1) chk("after_rst_grant", 32'(grant_log[0]), 32'(2));
        req_valid = '0;
        cyc(10);

        // fairness with a late arrival
        do_reset();
        grant_log.delete();
        req_a[15:8] = 8'd45; req_b[15:8] = 8'd6; req_a[31:24] = 8'd200; req_b[31:24] = 8'd3;
        req_valid = 4'b0010;
        wait_grants(1, "fair_first");
        req_valid = 4'b1010;
        wait_grants(3, "fair");
        if (grant_log.size() >= 3) begin
            chk("fair0", 32'(grant_log[0]), 32'(1));
            chk("fair1", 32'(grant_log[1]), 32'(3));
            chk("fair2", 32'(grant_log[2]), 32'(1));
        end
        req_valid = '0;
        cyc(10);

        // random traffic
        for (int t = 0; t < 600; t++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_a     = $urandom;
            req_b     = $urandom;
            res_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        req_valid = '0;
        res_ready = 1'b1;
        cyc(20);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
    endtask

    // ---------------- MUL_LAT=1 single request ----------------
    task automatic run_small();
        s_rst_n = 1'b0; s_req_valid = '0; s_req_a = '0; s_req_b = '0; s_res_ready = 1'b1;
        cyc(3);
        s_rst_n = 1'b1;
        cyc(1);
        s_req_valid = 4'b0001; s_req_a[7:0] = 8'd13; s_req_b[7:0] = 8'd11;
        #2;
        chk("s_accept_ready", 32'(s_req_ready), 32'(1));
        cyc(1);
        s_req_valid = '0;
        chk("s_calc_busy", 32'(s_busy), 32'(1));
        chk("s_calc_res_valid", 32'(s_res_valid), 32'(0));
        chk("s_calc_ready", 32'(s_req_ready), 32'(0));
        cyc(1);
        chk("s_res_valid", 32'(s_res_valid), 32'(1));
        chk("s_res_product", 32'(s_res_product), 32'(143));
        chk("s_res_id", 32'(s_res_id), 32'(0));
        chk("s_hold_busy", 32'(s_busy), 32'(1));
        chk("s_hold_ready", 32'(s_req_ready), 32'(0));
        cyc(1);
        chk("s_done_busy", 32'(s_busy), 32'(0));
        chk("s_done_res_valid", 32'(s_res_valid), 32'(0));
    endtask

    // ---------------- top-level sequence and report ----------------
    initial begin
        fork
            run_main();
            run_small();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
